// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates two writeback sources onto one register-file write port
// and tracks long-latency destinations so the issue stage can stall on RAW hazards.
module regfile_wb_scheduler #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_reg,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_reg,
   input  logic [DATA_W-1:0] b_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_reg,
   input  logic [ADDR_W-1:0] query_addr1,
   input  logic [ADDR_W-1:0] query_addr2,
   output logic              busy1,
   output logic              busy2,
   output logic              write_en,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] write_data
);
   localparam int N = 1 << ADDR_W;
   logic          r_last_b;
   logic [N-1:0]  r_pending;
   logic [N-1:0]  w_set;
   logic [N-1:0]  w_clr;
   logic [N-1:0]  w_one;
   assign w_one   = {{(N-1){1'b0}}, 1'b1};
   assign a_ready = rst_n && a_valid && (!b_valid || r_last_b);
   assign b_ready = rst_n && b_valid && (!a_valid || !r_last_b);
   assign w_set   = rsv_en ? (w_one << rsv_reg) : '0;
   assign w_clr   = b_ready ? (w_one << b_reg) : '0;
   assign busy1   = (query_addr1 != '0) && (r_pending[query_addr1] || (write_en && write_reg == query_addr1));
   assign busy2   = (query_addr2 != '0) && (r_pending[query_addr2] || (write_en && write_reg == query_addr2));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_b   <= 1'b1;
         r_pending  <= '0;
         write_en   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
      end else begin
         if (a_valid && b_valid) r_last_b <= !r_last_b;
         // set after clear so a fresh reservation survives a same-cycle retire
         r_pending <= ((r_pending & ~w_clr) | w_set) & ~w_one;
         write_en  <= a_ready ? (a_reg != '0) : b_ready ? (b_reg != '0) : 1'b0;
         if (a_ready) begin
            write_reg  <= a_reg;
            write_data <= a_data;
         end else if (b_ready) begin
            write_reg  <= b_reg;
            write_data <= b_data;
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed vector table, reset corner case and randomized traffic
// checked against a per-cycle behavioural model of the scheduler.
module tb_regfile_wb_scheduler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0, rsv_en = 1'b0;
   logic        a_ready, b_ready, busy1, busy2, write_en;
   logic [4:0]  a_reg = '0, b_reg = '0, rsv_reg = '0, query_addr1 = '0, query_addr2 = '0, write_reg;
   logic [31:0] a_data = '0, b_data = '0, write_data;

   int checks = 0;
   int errors = 0;
   int conflicts = 0;
   bit m_pend [32];
   logic [31:0] m_rf [32];
   logic [31:0] obs_rf [32];
   logic        m_we = 1'b0;
   logic [4:0]  m_wreg = '0;
   logic [31:0] m_wdata = '0;
   logic        a_fire = 1'b0, b_fire = 1'b0;

   typedef struct {
      logic av; logic [4:0] ar; logic [31:0] ad;
      logic bv; logic [4:0] br; logic [31:0] bd;
      logic rv; logic [4:0] rr; logic [4:0] q1; logic [4:0] q2;
      logic ea; logic eb; logic eb1; logic eb2;
      logic ewe; logic [4:0] ewr; logic [31:0] ewd;
   } vec_t;
   vec_t tbl [12];

   regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .rsv_en(rsv_en), .rsv_reg(rsv_reg),
      .query_addr1(query_addr1), .query_addr2(query_addr2),
      .busy1(busy1), .busy2(busy2),
      .write_en(write_en), .write_reg(write_reg), .write_data(write_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic exp_busy(input logic [4:0] q);
      return (q != 0) && (m_pend[q] || (m_we && m_wreg == q));
   endfunction

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_we = 1'b0; m_wreg = '0; m_wdata = '0; conflicts = 0;
   endtask

   // One cycle: called just after an edge with inputs applied; returns just after the next edge.
   task automatic cyc();
      logic ea, eb;
      #1;
      // conflicts alternate starting with A after reset
      ea = a_valid && (!b_valid || conflicts % 2 == 0);
      eb = b_valid && (!a_valid || conflicts % 2 == 1);
      chk("a_ready", a_ready, ea);
      chk("b_ready", b_ready, eb);
      chk("busy1", busy1, exp_busy(query_addr1));
      chk("busy2", busy2, exp_busy(query_addr2));
      if (write_en) obs_rf[write_reg] = write_data;
      @(posedge clk);
      if (m_we) m_rf[m_wreg] = m_wdata;
      if (a_valid && b_valid) conflicts++;
      if (ea) begin m_we = (a_reg != 0); m_wreg = a_reg; m_wdata = a_data; end
      else if (eb) begin m_we = (b_reg != 0); m_wreg = b_reg; m_wdata = b_data; end
      else m_we = 1'b0;
      if (eb) m_pend[b_reg] = 1'b0;
      if (rsv_en) m_pend[rsv_reg] = 1'b1;
      m_pend[0] = 1'b0;
      a_fire = ea; b_fire = eb;
      #1;
      chk("write_en", write_en, m_we);
      chk("write_reg", write_reg, m_wreg);
      chk("write_data", write_data, m_wdata);
   endtask

   task automatic idle();
      a_valid = 0; b_valid = 0; rsv_en = 0;
   endtask

   initial begin
      foreach (m_rf[i]) begin m_rf[i] = '0; obs_rf[i] = '0; end
      model_reset();
      tbl[0]  = '{1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22, 1'b1,5'd7, 5'd7,5'd3, 1'b1,1'b0,1'b0,1'b0, 1'b1,5'd3,32'h11};
      tbl[1]  = '{1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22, 1'b0,5'd0, 5'd7,5'd3, 1'b0,1'b1,1'b1,1'b1, 1'b1,5'd4,32'h22};
      tbl[2]  = '{1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22, 1'b0,5'd0, 5'd7,5'd3, 1'b1,1'b0,1'b1,1'b0, 1'b1,5'd3,32'h11};
      tbl[3]  = '{1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22, 1'b0,5'd0, 5'd7,5'd3, 1'b0,1'b1,1'b1,1'b1, 1'b1,5'd4,32'h22};
      tbl[4]  = '{1'b1,5'd0,32'hFFFFFFFF, 1'b0,5'd0,32'h0, 1'b1,5'd0, 5'd0,5'd4, 1'b1,1'b0,1'b0,1'b1, 1'b0,5'd0,32'hFFFFFFFF};
      tbl[5]  = '{1'b0,5'd0,32'h0, 1'b1,5'd7,32'h77, 1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b1,1'b1,1'b0, 1'b1,5'd7,32'h77};
      tbl[6]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b0,1'b1,1'b0, 1'b0,5'd7,32'h77};
      tbl[7]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,5'd7,32'h77};
      tbl[8]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd9, 5'd9,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,5'd7,32'h77};
      tbl[9]  = '{1'b0,5'd0,32'h0, 1'b1,5'd9,32'h99, 1'b1,5'd9, 5'd9,5'd0, 1'b0,1'b1,1'b1,1'b0, 1'b1,5'd9,32'h99};
      tbl[10] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd9,5'd9, 1'b0,1'b0,1'b1,1'b1, 1'b0,5'd9,32'h99};
      tbl[11] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd9,5'd0, 1'b0,1'b0,1'b1,1'b0, 1'b0,5'd9,32'h99};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_write_en", write_en, 1'b0);
      chk("reset_write_reg", write_reg, 5'd0);
      chk("reset_write_data", write_data, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         a_valid = tbl[i].av; a_reg = tbl[i].ar; a_data = tbl[i].ad;
         b_valid = tbl[i].bv; b_reg = tbl[i].br; b_data = tbl[i].bd;
         rsv_en = tbl[i].rv; rsv_reg = tbl[i].rr;
         query_addr1 = tbl[i].q1; query_addr2 = tbl[i].q2;
         #1;
         chk($sformatf("vec%0d_a_ready", i), a_ready, tbl[i].ea);
         chk($sformatf("vec%0d_b_ready", i), b_ready, tbl[i].eb);
         chk($sformatf("vec%0d_busy1", i), busy1, tbl[i].eb1);
         chk($sformatf("vec%0d_busy2", i), busy2, tbl[i].eb2);
         cyc();
         chk($sformatf("vec%0d_write_en", i), write_en, tbl[i].ewe);
         chk($sformatf("vec%0d_write_reg", i), write_reg, tbl[i].ewr);
         chk($sformatf("vec%0d_write_data", i), write_data, tbl[i].ewd);
      end

      idle(); rsv_en = 1; rsv_reg = 5'd12; cyc();
      idle(); a_valid = 1; a_reg = 5'd5; a_data = 32'h5555; cyc();
      idle(); a_valid = 1; b_valid = 1; a_reg = 5'd6; b_reg = 5'd8;
      query_addr1 = 5'd12; query_addr2 = 5'd9;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_a_ready", a_ready, 1'b0);
      chk("rst_b_ready", b_ready, 1'b0);
      chk("rst_busy1", busy1, 1'b0);
      chk("rst_busy2", busy2, 1'b0);
      chk("rst_write_en", write_en, 1'b0);
      chk("rst_write_reg", write_reg, 5'd0);
      chk("rst_write_data", write_data, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_a_first", {a_ready, b_ready}, 2'b10);
      cyc();

      for (int n = 0; n < 400; n++) begin
         if (!a_valid || a_fire) begin
            a_valid = $urandom_range(0, 2) != 0; a_reg = 5'($urandom); a_data = $urandom;
         end
         if (!b_valid || b_fire) begin
            b_valid = $urandom_range(0, 2) != 0; b_reg = 5'($urandom); b_data = $urandom;
         end
         rsv_en = $urandom_range(0, 3) == 0; rsv_reg = 5'($urandom);
         query_addr1 = 5'($urandom);
         query_addr2 = ($urandom_range(0, 1) == 0) ? b_reg : 5'($urandom);
         cyc();
      end
      idle();
      repeat (3) cyc();
      for (int i = 0; i < 32; i++) chk($sformatf("rf%0d", i), obs_rf[i], m_rf[i]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
